// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: funct field codes,
// FSM state encoding, operation kinds and the funct decoder.
package mdu_pkg;

  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_MTHI,
    OP_MTLO,
    OP_MULT,
    OP_MULTU,
    OP_DIV,
    OP_DIVU
  } op_kind_t;

  // Maps the funct field to the operation this block handles; anything
  // else (including MFHI/MFLO, which only read HI/LO) is OP_NONE.
  function automatic op_kind_t decode_funct(input logic [5:0] funct);
    case (funct)
      F_MTHI:  return OP_MTHI;
      F_MTLO:  return OP_MTLO;
      F_MULT:  return OP_MULT;
      F_MULTU: return OP_MULTU;
      F_DIV:   return OP_DIV;
      F_DIVU:  return OP_DIVU;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the MDU datapath, purely combinational.
//  multiply: {acc_hi,acc_lo} shift-add, operand = multiplicand, multiplier in acc_lo
//  divide:   restoring trial subtract, acc_hi = partial remainder,
//            acc_lo = dividend bits shifting out / quotient bits shifting in
module mdu_iter_step
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             fits;

  // Compute both step flavours and select by operation type.
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    fits    = (shifted >= {1'b0, operand});
    // Only used when fits; the result is then below operand and fits in WIDTH.
    trial   = shifted[WIDTH-1:0] - operand;
    if (is_div) begin
      next_hi = fits ? trial : shifted[WIDTH-1:0];
      next_lo = {acc_lo[WIDTH-2:0], fits};
    end else begin
      next_hi = sum[WIDTH:1];
      next_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide sequencer owning HI/LO. Runs MULT/MULTU/DIV/DIVU
// over WIDTH iteration cycles plus one sign-fix cycle, serves MTHI/MTLO, and
// stalls the pipeline while busy.
// Optional feature: define MDU_FLUSH_EN to add the flush port (abort in-flight op).
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mf_req,
`ifdef MDU_FLUSH_EN
  input  logic             flush,
`endif
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state, next_state;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic             op_div, neg_q, neg_r, div_zero;

  op_kind_t         kind;
  logic             abort, accept, is_md, is_div_kind, signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix, res_hi, res_lo;

`ifdef MDU_FLUSH_EN
  assign abort = flush;
`else
  assign abort = 1'b0;
`endif

  // Decode, operand magnitude preparation and result sign correction.
  always_comb begin
    kind        = decode_funct(funct);
    is_md       = (kind inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
    is_div_kind = (kind inside {OP_DIV, OP_DIVU});
    signed_op   = (kind inside {OP_MULT, OP_DIV});
    accept      = (state == S_IDLE) && start && !abort;
    a_neg       = signed_op && rs_val[WIDTH-1];
    b_neg       = signed_op && rt_val[WIDTH-1];
    abs_a       = a_neg ? -rs_val : rs_val;
    abs_b       = b_neg ? -rt_val : rt_val;
    prod        = {acc_hi, acc_lo};
    prod_fix    = neg_q ? -prod : prod;
    // Zero divisor leaves an all-ones magnitude quotient; it is reported
    // as all ones regardless of signs, while the remainder naturally
    // reconstructs the dividend after sign correction.
    q_fix       = div_zero ? '1 : (neg_q ? -acc_lo : acc_lo);
    r_fix       = neg_r ? -acc_hi : acc_hi;
    res_hi      = op_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
    res_lo      = op_div ? q_fix : prod_fix[WIDTH-1:0];
    busy        = (state != S_IDLE);
    stall       = busy && (start || mf_req);
  end

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (op_div),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .operand (opnd),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic: IDLE -> CALC (WIDTH steps) -> FIX -> IDLE.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (accept && is_md) next_state = S_CALC;
      S_CALC: begin
        if (abort)               next_state = S_IDLE;
        else if (counter == '0)  next_state = S_FIX;
      end
      S_FIX:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath registers, HI/LO and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter  <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (kind)
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                counter  <= CW'(WIDTH - 1);
                acc_hi   <= '0;
                op_div   <= is_div_kind;
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= is_div_kind && a_neg;
                div_zero <= is_div_kind && (rt_val == '0);
                // Multiply: multiplier shifts through acc_lo.
                // Divide: dividend shifts out of acc_lo.
                acc_lo   <= is_div_kind ? abs_a : abs_b;
                opnd     <= is_div_kind ? abs_b : abs_a;
              end
              default: ;
            endcase
          end
        end
        S_CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          if (counter != '0) counter <= counter - CW'(1);
        end
        S_FIX: begin
          if (!abort) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer (WIDTH=32).
// Cycle 0 is the cycle start is presented; results are expected in cycle 34.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] rs_val, rt_val;
  logic        mf_req;
`ifdef MDU_FLUSH_EN
  logic        flush;
`endif
  logic [31:0] hi, lo;
  logic        busy, done, stall;

  int checks = 0;
  int errors = 0;

  mdu_sequencer #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct  (funct),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .mf_req (mf_req),
`ifdef MDU_FLUSH_EN
    .flush  (flush),
`endif
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done),
    .stall  (stall)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    funct  = f;
    rs_val = a;
    rt_val = b;
  endtask

  // Issue an op in cycle 0 and advance to the negedge of cycle 34.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    issue(f, a, b);
    step();
    start = 1'b0;
    repeat (33) step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++;
    if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo got %h want 0", {hi, lo}); end
    checks++;
    if ({busy, done, stall} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, stall}); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_multu();
    int first_done = -1;
    issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    step();
    start = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL multu_busy cycle %0d got busy=%b done=%b want 1/0", c, busy, done);
      end
      checks++;
      if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL multu_hold cycle %0d got %h want 0", c, {hi, lo}); end
      step();
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL multu_done got busy=%b done=%b want 0/1", busy, done);
    end
    checks++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      errors++; $display("FAIL multu_result got %h_%h want fffffffe_00000001", hi, lo);
    end
    step();
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse got %b want 0", done); end
    if (done === 1'b1) first_done = 35;
    step();
  endtask

  task automatic test_signed();
    run_op(F_MULT, 32'hFFFFFFFD, 32'd7);
    checks++;
    if (done !== 1'b1 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
      errors++; $display("FAIL mult_neg got done=%b %h_%h want 1 ffffffff_ffffffeb", done, hi, lo);
    end
    step();
    run_op(F_DIV, 32'hFFFFFFF9, 32'd2);
    checks++;
    if (done !== 1'b1 || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL div_neg got done=%b lo=%h hi=%h want 1 fffffffd ffffffff", done, lo, hi);
    end
    step();
  endtask

  task automatic test_div_edges();
    run_op(F_DIVU, 32'd100, 32'd0);
    checks++;
    if (done !== 1'b1 || lo !== 32'hFFFFFFFF || hi !== 32'd100) begin
      errors++; $display("FAIL divu_zero got done=%b lo=%h hi=%h want 1 ffffffff 00000064", done, lo, hi);
    end
    step();
    run_op(F_DIV, 32'hFFFFFFFB, 32'd0);
    checks++;
    if (lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFFB) begin
      errors++; $display("FAIL div_zero_neg got lo=%h hi=%h want ffffffff fffffffb", lo, hi);
    end
    step();
    run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF);
    checks++;
    if (lo !== 32'h80000000 || hi !== 32'd0) begin
      errors++; $display("FAIL div_minneg got lo=%h hi=%h want 80000000 00000000", lo, hi);
    end
    step();
  endtask

  task automatic test_stall_mf();
    issue(F_MULT, 32'd5, 32'hFFFFFFFA);
    step();
    issue(F_MFLO, 32'd0, 32'd0);
    mf_req = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL mf_stall cycle %0d got %b want 1", c, stall); end
      step();
    end
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || lo !== 32'hFFFFFFE2 || hi !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL mf_release got stall=%b hi=%h lo=%h want 0 ffffffff ffffffe2", stall, hi, lo);
    end
    step();
    start  = 1'b0;
    mf_req = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mf_not_accepted got busy=%b want 0", busy); end
    step();
  endtask

  task automatic test_back_to_back();
    issue(F_MULTU, 32'd3, 32'd4);
    step();
    issue(F_DIVU, 32'd100, 32'd7);
    repeat (33) step();
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || stall !== 1'b0 || hi !== 32'd0 || lo !== 32'd12) begin
      errors++; $display("FAIL b2b_first got done=%b busy=%b stall=%b %h_%h want 1 0 0 0_c", done, busy, stall, hi, lo);
    end
    step();
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b want 1", busy); end
    repeat (33) step();
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || lo !== 32'd14 || hi !== 32'd2) begin
      errors++; $display("FAIL b2b_second got done=%b lo=%h hi=%h want 1 e 2", done, lo, hi);
    end
    step();
  endtask

  task automatic test_mt();
    issue(F_MTHI, 32'h1234, 32'd0);
    step();
    issue(F_MTLO, 32'h5678, 32'd0);
    @(negedge clk);
    checks++;
    if (hi !== 32'h1234 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mthi got hi=%h busy=%b done=%b want 1234 0 0", hi, busy, done);
    end
    step();
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (lo !== 32'h5678 || hi !== 32'h1234 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mtlo got hi=%h lo=%h busy=%b done=%b want 1234 5678 0 0", hi, lo, busy, done);
    end
    step();
  endtask

  task automatic test_reset_mid_op();
    logic saw_done = 1'b0;
    issue(F_DIV, 32'd1000, 32'd3);
    step();
    start = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || {hi, lo} !== 64'd0) begin
      errors++; $display("FAIL reset_mid got busy=%b done=%b %h_%h want 0 0 0", busy, done, hi, lo);
    end
    for (int c = 0; c < 30; c++) begin
      step();
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL reset_mid_nodone got %b want 0", saw_done); end
    step();
  endtask

`ifdef MDU_FLUSH_EN
  task automatic test_flush();
    logic saw_done = 1'b0;
    issue(F_MTHI, 32'hAAAA, 32'd0);
    step();
    issue(F_MTLO, 32'hBBBB, 32'd0);
    step();
    issue(F_DIV, 32'd1000, 32'd3);
    step();
    start = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'hAAAA || lo !== 32'hBBBB) begin
      errors++; $display("FAIL flush_mid got busy=%b %h_%h want 0 aaaa_bbbb", busy, hi, lo);
    end
    for (int c = 0; c < 30; c++) begin
      step();
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL flush_nodone got %b want 0", saw_done); end
    step();
    flush = 1'b1;
    issue(F_MTHI, 32'hCCCC, 32'd0);
    step();
    flush = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (hi !== 32'hAAAA) begin errors++; $display("FAIL flush_idle_block got hi=%h want aaaa", hi); end
    step();
  endtask
`endif

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    funct  = 6'd0;
    rs_val = 32'd0;
    rt_val = 32'd0;
    mf_req = 1'b0;
`ifdef MDU_FLUSH_EN
    flush  = 1'b0;
`endif
    test_reset();
    test_multu();
    test_signed();
    test_div_edges();
    test_stall_mf();
    test_back_to_back();
    test_mt();
    test_reset_mid_op();
`ifdef MDU_FLUSH_EN
    test_flush();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
